// File: rtl/conv_matrix_buf.sv
// ---------------------------------------------------------------------------
// conv_matrix_buf
//
// ROWS x COLS matrix buffer for convolution front-ends.  A matrix is loaded
// as a raster stream of N = ROWS*COLS words and then streamed back out,
// either in row-major or column-major (transposed) order.  The contents are
// kept after a readback, so the same matrix can be read any number of times.
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start_load  in   pulse: begin raster load of N words (IDLE or FULL)
//   din_valid   in   din holds a word to write (only honoured in LOAD)
//   din         in   write data, DATA_W bits, stored unmodified
//   din_ready   out  block accepts din this cycle (state LOAD)
//   start_read  in   pulse: begin readback of N words (FULL only)
//   col_major   in   readback order, sampled with an accepted start_read
//   dout        out  read data, holds its value between valid words
//   dout_valid  out  dout valid this cycle
//   dout_last   out  dout is the Nth word of a readback
//   full        out  all N words loaded since the last start_load
//   busy        out  state is CLEAR, LOAD or READ
//   wr_count    out  words accepted in the current load
//
// Build option
//   CONV_MATRIX_BUF_MEM_CLEAR_EN  when defined, the block walks through the
//   whole memory writing zero after every reset release (state CLEAR) before
//   it becomes IDLE.  When undefined there is no clear logic at all.
// ---------------------------------------------------------------------------
module conv_matrix_buf #(
    parameter  int DATA_W = 8,
    parameter  int ROWS   = 8,
    parameter  int COLS   = 8,
    localparam int N      = ROWS * COLS,
    localparam int CW     = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              din_ready,
    input  logic              start_read,
    input  logic              col_major,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_last,
    output logic              full,
    output logic              busy,
    output logic [CW-1:0]     wr_count
);

    localparam int AW = $clog2(N);      // memory address width
    localparam int RW = $clog2(ROWS);   // row counter width
    localparam int KW = $clog2(COLS);   // column counter width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FULL  = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Load side
    logic [CW-1:0] wr_count_q, wr_count_d;

    // Read address generator
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] rd_cnt_q,  rd_cnt_d;
    logic [RW-1:0] rd_row_q,  rd_row_d;
    logic [KW-1:0] rd_col_q,  rd_col_d;
    logic          rd_order_q, rd_order_d;   // 1 = column-major

    // Output pipeline
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;
    logic              dout_last_q;

    // Storage and its single write port
    logic [DATA_W-1:0] mem_q [N];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Handshake decodes
    logic idle_open;   // IDLE may accept start_load (no clear pending)
    logic load_go;
    logic read_go;
    logic wr_accept;
    logic wr_last;
    logic rd_issue;
    logic rd_final;

`ifdef CONV_MATRIX_BUF_MEM_CLEAR_EN
    logic          clr_pending_q, clr_pending_d;
    logic [AW-1:0] clr_addr_q,    clr_addr_d;
    logic          clr_done;

    // The pending flag is set by reset, so the block passes through exactly
    // one IDLE cycle after release and then sweeps the memory.
    assign idle_open = ~clr_pending_q;
    assign clr_done  = (clr_addr_q == AW'(N - 1));
`else
    assign idle_open = 1'b1;
`endif

    // start_load wins over start_read when both arrive in FULL.
    assign load_go   = start_load &
                       (((state_q == ST_IDLE) & idle_open) | (state_q == ST_FULL));
    assign read_go   = start_read & ~start_load & (state_q == ST_FULL);
    assign wr_accept = (state_q == ST_LOAD) & din_valid;
    assign wr_last   = wr_accept & (wr_count_q == CW'(N - 1));
    assign rd_issue  = (state_q == ST_READ);
    assign rd_final  = rd_issue & (rd_cnt_q == AW'(N - 1));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
`ifdef CONV_MATRIX_BUF_MEM_CLEAR_EN
                if (clr_pending_q) begin
                    state_d = ST_CLEAR;
                end else if (load_go) begin
                    state_d = ST_LOAD;
                end
`else
                if (load_go) begin
                    state_d = ST_LOAD;
                end
`endif
            end
`ifdef CONV_MATRIX_BUF_MEM_CLEAR_EN
            ST_CLEAR: begin
                if (clr_done) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_LOAD: begin
                if (wr_last) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (load_go) begin
                    state_d = ST_LOAD;
                end else if (read_go) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // Returning to FULL after the last address means a new
                // start_read can be taken in the cycle that shows dout_last.
                if (rd_final) begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        din_ready = (state_q == ST_LOAD);
        busy      = (state_q == ST_CLEAR) | (state_q == ST_LOAD) | (state_q == ST_READ);
        // The matrix stays complete while it is being read back.
        full      = (state_q == ST_FULL) | (state_q == ST_READ);
    end

    // -----------------------------------------------------------------------
    // Load counter: doubles as the raster write address r*COLS+c
    // -----------------------------------------------------------------------
    always_comb begin
        wr_count_d = wr_count_q;
        if (load_go) begin
            wr_count_d = '0;
        end else if (wr_accept) begin
            wr_count_d = wr_count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Read address generator
    //   row-major:    address simply increments
    //   column-major: row index runs fastest; stepping a row adds COLS, and
    //                 wrapping the row restarts at the next column's top.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        rd_row_d   = rd_row_q;
        rd_col_d   = rd_col_q;
        rd_order_d = rd_order_q;
        if (read_go) begin
            rd_addr_d  = '0;
            rd_cnt_d   = '0;
            rd_row_d   = '0;
            rd_col_d   = '0;
            rd_order_d = col_major;
        end else if (rd_issue) begin
            rd_cnt_d = rd_cnt_q + AW'(1);
            if (!rd_order_q) begin
                rd_addr_d = rd_addr_q + AW'(1);
            end else if (rd_row_q == RW'(ROWS - 1)) begin
                rd_row_d  = '0;
                rd_col_d  = rd_col_q + KW'(1);
                rd_addr_d = AW'(rd_col_q) + AW'(1);
            end else begin
                rd_row_d  = rd_row_q + RW'(1);
                rd_addr_d = rd_addr_q + AW'(COLS);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            rd_order_q <= 1'b0;
        end else begin
            rd_addr_q  <= rd_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_row_q   <= rd_row_d;
            rd_col_q   <= rd_col_d;
            rd_order_q <= rd_order_d;
        end
    end

    // -----------------------------------------------------------------------
    // Memory clear sweep (optional)
    // -----------------------------------------------------------------------
`ifdef CONV_MATRIX_BUF_MEM_CLEAR_EN
    always_comb begin
        clr_pending_d = clr_pending_q;
        clr_addr_d    = '0;
        if ((state_q == ST_IDLE) && clr_pending_q) begin
            clr_pending_d = 1'b0;
        end
        if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_pending_q <= 1'b1;
            clr_addr_q    <= '0;
        end else begin
            clr_pending_q <= clr_pending_d;
            clr_addr_q    <= clr_addr_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Memory write port: load data, or zeros during the clear sweep
    // -----------------------------------------------------------------------
    always_comb begin
        mem_we    = wr_accept;
        mem_waddr = AW'(wr_count_q);
        mem_wdata = din;
`ifdef CONV_MATRIX_BUF_MEM_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = '0;
        end
`endif
    end

    // No reset on the array itself so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Registered read: data, valid and last line up one cycle after the
    // address is issued.  dout only loads on a read so it holds between
    // streams.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            dout_valid_q <= rd_issue;
            dout_last_q  <= rd_final;
            if (rd_issue) begin
                dout_q <= mem_q[rd_addr_q];
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_conv_matrix_buf.sv
// ---------------------------------------------------------------------------
// tb_conv_matrix_buf
//
// Self-checking bench for conv_matrix_buf with default parameters (8x8, 8-bit).
// Expected readback words are pushed to a queue when a read is started and
// compared by a monitor whenever the block presents dout_valid.
// ---------------------------------------------------------------------------
module tb_conv_matrix_buf;

    localparam int DATA_W = 8;
    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int N      = ROWS * COLS;
    localparam int CW     = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_load = 1'b0;
    logic              din_valid = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              din_ready;
    logic              start_read = 1'b0;
    logic              col_major = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_last;
    logic              full;
    logic              busy;
    logic [CW-1:0]     wr_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] img [N];

    conv_matrix_buf #(
        .DATA_W(DATA_W),
        .ROWS  (ROWS),
        .COLS  (COLS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_load(start_load),
        .din_valid (din_valid),
        .din       (din),
        .din_ready (din_ready),
        .start_read(start_read),
        .col_major (col_major),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_last (dout_last),
        .full      (full),
        .busy      (busy),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every valid output word must match the queue head.
    always @(negedge clk) begin
        if (rst_n && dout_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dout got dout=%0d last=%0b required no valid word",
                         $signed(dout), dout_last);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (dout !== e.data || dout_last !== e.last) begin
                    errors++;
                    $display("FAIL stream_word got dout=%0d last=%0b required dout=%0d last=%0b",
                             $signed(dout), dout_last, $signed(e.data), e.last);
                end
            end
        end
    end

    // Independent order model: i-th word of the stream.
    task automatic push_stream(input bit cm);
        for (int i = 0; i < N; i++) begin
            exp_t e;
            int   a;
            a      = cm ? ((i % ROWS) * COLS + (i / ROWS)) : i;
            e.data = img[a];
            e.last = (i == N - 1);
            exp_q.push_back(e);
        end
    endtask

    // Pulse start_load, then feed n words of img (optionally with gaps).
    task automatic drive_load(input int n, input bit gapped);
        @(posedge clk); #1 start_load = 1'b1;
        @(posedge clk); #1 start_load = 1'b0;
        for (int k = 0; k < n; k++) begin
            din_valid = 1'b1;
            din       = img[k];
            @(posedge clk); #1;
            if (gapped) begin
                din_valid = 1'b0;
                din       = 8'h5A;
                @(posedge clk); #1;
            end
        end
        din_valid = 1'b0;
    endtask

    // Pulse start_read with the given order; returns just after the edge
    // that sampled it. col_major is flipped afterwards to prove it is sampled.
    task automatic drive_read(input bit cm);
        push_stream(cm);
        @(posedge clk); #1 start_read = 1'b1; col_major = cm;
        @(posedge clk); #1 start_read = 1'b0; col_major = ~cm;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3 * N) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d words outstanding required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        int n;
        repeat (2) @(posedge clk);
        #1;
        n = 0;
        while (busy && n < 4 * N) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({din_ready, dout_valid, dout_last, full, busy} !== 5'b0 || wr_count !== '0 || dout !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%0b v=%0b l=%0b full=%0b busy=%0b cnt=%0d dout=%0d required all 0",
                     din_ready, dout_valid, dout_last, full, busy, wr_count, dout);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || din_ready !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%0b rdy=%0b full=%0b required 0 0 0", busy, din_ready, full);
        end
`ifndef CONV_MATRIX_BUF_MEM_CLEAR_EN
        // start_read in IDLE must do nothing (monitor flags any dout_valid).
        @(posedge clk); #1 start_read = 1'b1;
        @(posedge clk); #1 start_read = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL idle_read_ignored got busy=%0b full=%0b required 0 0", busy, full);
        end
`endif
        settle();
        $display("test_reset done");
    endtask

    task automatic test_row_major();
        for (int k = 0; k < N; k++) img[k] = DATA_W'(k);
        drive_load(N - 1, 1'b0);
        checks++;
        if (full !== 1'b0 || wr_count !== CW'(N - 1) || busy !== 1'b1 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_63 got full=%0b cnt=%0d busy=%0b rdy=%0b required 0 63 1 1",
                     full, wr_count, busy, din_ready);
        end
        din_valid = 1'b1; din = img[N - 1];
        @(posedge clk); #1 din_valid = 1'b0;
        checks++;
        if (full !== 1'b1 || wr_count !== CW'(N) || busy !== 1'b0 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_64 got full=%0b cnt=%0d busy=%0b rdy=%0b required 1 64 0 0",
                     full, wr_count, busy, din_ready);
        end
        drive_read(1'b0);
        checks++;
        if (dout_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_latency1 got valid=%0b busy=%0b required 0 1", dout_valid, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'd0) begin
            errors++;
            $display("FAIL read_latency2 got valid=%0b dout=%0d required 1 0", dout_valid, dout);
        end
        wait_drain("row_major");
        checks++;
        if (full !== 1'b1 || busy !== 1'b0 || dout !== 8'd63) begin
            errors++;
            $display("FAIL after_read got full=%0b busy=%0b dout=%0d required 1 0 63", full, busy, dout);
        end
        $display("test_row_major done");
    endtask

    task automatic test_col_major();
        drive_read(1'b1);
        wait_drain("col_major");
        $display("test_col_major done");
    endtask

    task automatic test_din_ignored();
        din_valid = 1'b1; din = 8'hEE;
        repeat (5) @(posedge clk);
        #1 din_valid = 1'b0;
        checks++;
        if (wr_count !== CW'(N) || full !== 1'b1) begin
            errors++;
            $display("FAIL din_in_full got cnt=%0d full=%0b required 64 1", wr_count, full);
        end
        drive_read(1'b0);
        wait_drain("din_ignored");
        $display("test_din_ignored done");
    endtask

    task automatic test_gapped_load();
        int bad;
        for (int k = 0; k < N; k++) img[k] = DATA_W'(k + 128);
        @(posedge clk); #1 start_load = 1'b1;
        @(posedge clk); #1 start_load = 1'b0;
        bad = 0;
        for (int k = 0; k < N; k++) begin
            din_valid = 1'b1; din = img[k];
            @(posedge clk); #1;
            if (wr_count !== CW'(k + 1)) bad++;
            din_valid = 1'b0; din = 8'h5A;
            @(posedge clk); #1;
            if (wr_count !== CW'(k + 1)) bad++;
        end
        checks++;
        if (bad != 0 || wr_count !== CW'(N) || full !== 1'b1) begin
            errors++;
            $display("FAIL gapped_count got cnt=%0d full=%0b bad_steps=%0d required 64 1 0", wr_count, full, bad);
        end
        drive_read(1'b0);
        wait_drain("gapped");
        $display("test_gapped_load done");
    endtask

    task automatic test_back_to_back();
        int n;
        drive_read(1'b0);
        n = 0;
        while (dout_last !== 1'b1 && n < N + 8) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (dout_last !== 1'b1 || full !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_last got last=%0b full=%0b busy=%0b required 1 1 0", dout_last, full, busy);
        end else begin
            // start_read is sampled in the cycle that shows dout_last
            push_stream(1'b1);
            start_read = 1'b1; col_major = 1'b1;
            @(posedge clk); #1 start_read = 1'b0; col_major = 1'b0;
            checks++;
            if (busy !== 1'b1 || dout_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_accept got busy=%0b valid=%0b required 1 0", busy, dout_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (dout_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_first got valid=%0b required 1", dout_valid);
            end
        end
        wait_drain("back_to_back");
        $display("test_back_to_back done");
    endtask

    task automatic test_load_wins();
        @(posedge clk); #1 start_load = 1'b1; start_read = 1'b1;
        @(posedge clk); #1 start_load = 1'b0; start_read = 1'b0;
        checks++;
        if (full !== 1'b0 || din_ready !== 1'b1 || wr_count !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_wins got full=%0b rdy=%0b cnt=%0d busy=%0b required 0 1 0 1",
                     full, din_ready, wr_count, busy);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_wins_hold got valid=%0b rdy=%0b required 0 1", dout_valid, din_ready);
        end
        $display("test_load_wins done");
    endtask

    task automatic test_reset_midload();
        for (int k = 0; k < N; k++) img[k] = DATA_W'(3 * k + 1);
        drive_load(20, 1'b0);
        checks++;
        if (wr_count !== CW'(20)) begin
            errors++;
            $display("FAIL midload_count got %0d required 20", wr_count);
        end
        #3 rst_n = 1'b0;
        #2;
        checks++;
        if ({din_ready, dout_valid, dout_last, full, busy} !== 5'b0 || wr_count !== '0 || dout !== '0) begin
            errors++;
            $display("FAIL async_reset got rdy=%0b v=%0b l=%0b full=%0b busy=%0b cnt=%0d dout=%0d required all 0",
                     din_ready, dout_valid, dout_last, full, busy, wr_count, dout);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        settle();
        for (int k = 0; k < N; k++) img[k] = DATA_W'(k ^ 8'h55);
        drive_load(N, 1'b0);
        checks++;
        if (full !== 1'b1 || wr_count !== CW'(N)) begin
            errors++;
            $display("FAIL reload got full=%0b cnt=%0d required 1 64", full, wr_count);
        end
        drive_read(1'b1);
        wait_drain("after_reset");
        $display("test_reset_midload done");
    endtask

`ifdef CONV_MATRIX_BUF_MEM_CLEAR_EN
    task automatic test_clear();
        int cnt;
        int bad;
        #3 rst_n = 1'b0;
        start_load = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        cnt = 0;
        for (int n = 0; n < 4 * N; n++) begin
            @(posedge clk); #1;
            if (busy) cnt++;
            else if (cnt > 0) break;
        end
        start_load = 1'b0;
        checks++;
        if (cnt != N) begin
            errors++;
            $display("FAIL clear_busy got %0d cycles required %0d", cnt, N);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || din_ready !== 1'b0 || wr_count !== '0) begin
            errors++;
            $display("FAIL clear_start_ignored got busy=%0b rdy=%0b cnt=%0d required 0 0 0", busy, din_ready, wr_count);
        end
        bad = 0;
        for (int i = 0; i < N; i++) if (dut.mem_q[i] !== '0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_mem got %0d nonzero words required 0", bad);
        end
        $display("test_clear done");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_row_major();
        test_col_major();
        test_din_ignored();
        test_gapped_load();
        test_back_to_back();
        test_load_wins();
        test_reset_midload();
`ifdef CONV_MATRIX_BUF_MEM_CLEAR_EN
        test_clear();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_matrix_buf.md
CONV_MATRIX_BUF -- requirements
Module: conv_matrix_buf

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, word width in bits (signed two's complement, stored unmodified).
REQ-002 SHALL provide parameter ROWS, default 8, matrix rows, range 2..64.
REQ-003 SHALL provide parameter COLS, default 8, matrix columns, range 2..64; N = ROWS*COLS, CW = $clog2(N+1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start_load  input  1  pulse: begin raster load of N words.
REQ-007 SHALL have port din_valid  input  1  din holds a word to write.
REQ-008 SHALL have port din  input  DATA_W  write data.
REQ-009 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-010 SHALL have port start_read  input  1  pulse: begin streamed readback of N words.
REQ-011 SHALL have port col_major  input  1  readback order, sampled with accepted start_read (0 row-major, 1 column-major).
REQ-012 SHALL have port dout  output  DATA_W  read data.
REQ-013 SHALL have port dout_valid  output  1  dout valid this cycle.
REQ-014 SHALL have port dout_last  output  1  dout is the Nth word of a readback.
REQ-015 SHALL have port full  output  1  all N words loaded since last start_load.
REQ-016 SHALL have port busy  output  1  state is CLEAR, LOAD or READ.
REQ-017 SHALL have port wr_count  output  CW  words accepted in current load.

Function
REQ-018 SHALL implement states IDLE, CLEAR, LOAD, FULL, READ; storage N x DATA_W, synchronous write, registered read.
REQ-019 IDLE: start_load -> LOAD, wr_count cleared; start_read ignored.
REQ-020 LOAD: din_ready=1; word written at raster address r*COLS+c on each din_valid cycle, wr_count+1; gaps in din_valid stall without penalty.
REQ-021 LOAD: on Nth accepted word -> FULL, full=1 next cycle; start_load/start_read ignored while in LOAD.
REQ-022 FULL: start_read -> READ; start_load -> LOAD (full=0, wr_count=0); both asserted same cycle: start_load wins.
REQ-023 READ: one read address issued per cycle for N cycles, first address in cycle after start_read sampled; then -> FULL, contents retained.
REQ-024 Row-major order: 0,1,...,N-1; column-major order: c*1 + r*COLS iterating r fastest (0,COLS,2*COLS,...,1,COLS+1,...,N-1).
REQ-025 dout_valid SHALL assert exactly 1 cycle after each issued address; first word 2 cycles after start_read sampled; N consecutive valid cycles, no gaps.
REQ-026 dout_last SHALL assert with the Nth dout_valid only; dout holds last value when dout_valid=0.
REQ-027 start_read sampled in the FULL cycle that carries dout_last SHALL be accepted, giving back-to-back streams without a bubble.
REQ-028 din_valid outside LOAD SHALL be ignored, no write.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, din_ready=0, dout_valid=0, dout_last=0, full=0, busy=0, wr_count=0, dout=0.
REQ-030 Reset mid-LOAD or mid-READ SHALL abort; memory contents undefined unless cleared per REQ-032; post-reset load starts at address 0.

Configuration
REQ-031 Macro CONV_MATRIX_BUF_MEM_CLEAR_EN SHALL select memory clear after reset.
REQ-032 Defined: after rst_n release enter CLEAR, write 0 to addresses 0..N-1 one per cycle (N cycles, busy=1, din_ready=0, starts ignored), then IDLE; undefined: leave reset directly to IDLE, no clear logic.

Verification
REQ-033 Defaults; load din=k (k=0..63) continuous -> full=1 one cycle after 64th word; start_read col_major=0 -> dout 0..63, first valid 2 cycles after start_read, dout_last on 63.
REQ-034 Same load, col_major=1 -> dout 0,8,16,...,56,1,9,...,55,63; dout_last on 63.
REQ-035 Load with din_valid toggling 1/0 and values -128..-65 -> wr_count reaches 64 after 128 cycles; readback returns -128..-65 exactly.
REQ-036 In FULL assert start_load and start_read together -> LOAD entered, full=0, no dout_valid.
REQ-037 Pull rst_n low after 20 words loaded -> all outputs 0 asynchronously; new load of 64 words reads back correctly.
REQ-038 With CONV_MATRIX_BUF_MEM_CLEAR_EN: after reset busy=1 for 64 cycles; load 0 words then force FULL path via full load of zeros not needed -- read after 64-word load of 5 at addresses 0..31 only is illegal; instead verify start_load ignored during CLEAR and memory reads 0 via backdoor.
